booth_macc_seq: RTL and testbench

Iterative, parametrised radix-4 Booth multiply-accumulate unit for the CNN MAC datapath. It extends the 8x8 combinational Booth multiplier with a generic operand width and a sequential datapath that evaluates one Booth digit per clock. It adds a signed accumulator with group clear and a sticky overflow flag, and uses valid/ready handshakes on both sides. It sits between the operand fetch stage and the output buffer of a processing element.

---
 rtl/booth_macc_seq.sv | 155 +++++++++++++++
 tb/tb_booth_macc_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_macc_seq.sv
// booth_macc_seq: iterative radix-4 Booth multiply-accumulate unit.
// One Booth digit of y is folded into the 2W-bit product per clock. The
// finished product is then added into a signed ACC_W-bit accumulator, which
// has group clear and a sticky signed-overflow flag.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready=1, waiting for an operand pair
// MUL   | one Booth digit per cycle, k = 0 .. W/2-1
// ACC   | add the product into the accumulator (clear first if clr)
// DONE  | out_valid=1, result/ovf held until out_ready
module booth_macc_seq #(
    parameter int W     = 8,
    parameter int ACC_W = 2*W+8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic             clr,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    localparam int ND = W/2;
    localparam int KW = $clog2(ND);
    localparam int PW = 2*W;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t           state;
    logic [W-1:0]     x_q;
    logic [W-1:0]     y_q;
    logic             clr_q;
    logic             last_q;
    logic [PW-1:0]    prod;
    logic [KW-1:0]    k;
    logic [ACC_W-1:0] acc;

    logic [W:0]       y_ext;
    logic [KW:0]      sh;
    logic [2:0]       trip;
    logic [W:0]       mag;
    logic             neg;
    logic [W:0]       pp;
    logic [PW-1:0]    pp_sh;
    logic [PW-1:0]    cin_sh;
    logic [PW-1:0]    prod_next;

    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] prod_sx;
    logic [ACC_W-1:0] sum;
    logic             ovf_step;

    // Booth recoding of digit k and the shifted partial product. The
    // negative digits use the one's complement; the +1 carry-in is added
    // at the same weight so no separate W+1-bit negator is needed.
    always_comb begin
        y_ext = {y_q, 1'b0};
        sh    = {k, 1'b0};
        trip  = y_ext[sh +: 3];
        mag   = '0;
        neg   = 1'b0;
        case (trip)
            3'b001, 3'b010: mag = {x_q[W-1], x_q};
            3'b011:         mag = {x_q, 1'b0};
            3'b100: begin
                mag = {x_q, 1'b0};
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = {x_q[W-1], x_q};
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
        pp        = neg ? ~mag : mag;
        pp_sh     = {{(PW-W-1){pp[W]}}, pp} << sh;
        cin_sh    = {{(PW-1){1'b0}}, neg} << sh;
        prod_next = prod + pp_sh + cin_sh;
    end

    // Accumulator adder with signed-overflow detection on the two addends.
    always_comb begin
        base     = clr_q ? '0 : acc;
        prod_sx  = ACC_W'($signed(prod));
        sum      = base + prod_sx;
        ovf_step = (base[ACC_W-1] == prod_sx[ACC_W-1]) &&
                   (sum[ACC_W-1] != base[ACC_W-1]);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            clr_q     <= 1'b0;
            last_q    <= 1'b0;
            prod      <= '0;
            k         <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q    <= x;
                        y_q    <= y;
                        clr_q  <= clr;
                        last_q <= last;
                        prod   <= '0;
                        k      <= '0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    prod <= prod_next;
                    if (k == KW'(ND-1)) begin
                        state <= ACC;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                ACC: begin
                    acc <= sum;
                    ovf <= (clr_q ? 1'b0 : ovf) | ovf_step;
                    if (last_q) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE) && !rst;
    assign result   = acc;

endmodule

// File: tb/tb_booth_macc_seq.sv
// Testbench for booth_macc_seq. Two W=8 instances (ACC_W=24 and ACC_W=16)
// share one stimulus stream so wrap/overflow behaviour can be compared
// against a reference model. Separate W=4 and W=16 instances cover other
// operand widths.
module tb_booth_macc_seq;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, clr, last, out_ready;
    logic [7:0] x8, y8;
    logic in_ready_a, out_valid_a, ovf_a;
    logic in_ready_b, out_valid_b, ovf_b;
    logic [23:0] result_a;
    logic [15:0] result_b;

    logic iv4, iv16, one;
    logic [3:0] x4, y4;
    logic [15:0] x16, y16;
    logic rdy4, ov4, ovf4, rdy16, ov16, ovf16;
    logic [15:0] res4;
    logic [39:0] res16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [23:0] r24;
        logic               o24;
        logic signed [15:0] r16;
        logic               o16;
    } exp8_t;

    exp8_t   q8[$];
    longint  qw[$];

    logic signed [23:0] m24;
    logic               m24o;
    logic signed [15:0] m16;
    logic               m16o;

    always #5 clk = ~clk;

    booth_macc_seq #(.W(8), .ACC_W(24)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .x(x8), .y(y8), .clr(clr), .last(last), .out_valid(out_valid_a),
        .out_ready(out_ready), .result(result_a), .ovf(ovf_a)
    );

    booth_macc_seq #(.W(8), .ACC_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .x(x8), .y(y8), .clr(clr), .last(last), .out_valid(out_valid_b),
        .out_ready(out_ready), .result(result_b), .ovf(ovf_b)
    );

    booth_macc_seq #(.W(4)) dut_w4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4),
        .x(x4), .y(y4), .clr(one), .last(one), .out_valid(ov4),
        .out_ready(one), .result(res4), .ovf(ovf4)
    );

    booth_macc_seq #(.W(16), .ACC_W(40)) dut_w16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16),
        .x(x16), .y(y16), .clr(one), .last(one), .out_valid(ov16),
        .out_ready(one), .result(res16), .ovf(ovf16)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_to(input string tag, input int n);
        checks++;
        assert (n < TO)
        else begin
            errors++;
            $error("FAIL %s: waited %0d cycles, limit %0d", tag, n, TO);
        end
    endtask

    // Reference model: exact product, wide add, range check for overflow.
    task automatic model8(input logic signed [7:0] a, input logic signed [7:0] b,
                          input logic c);
        longint p, s;
        p = longint'(a) * longint'(b);
        s = (c ? 64'sd0 : longint'(m24)) + p;
        m24o = (c ? 1'b0 : m24o) | (s > 64'sd8388607 || s < -64'sd8388608);
        m24 = 24'(s);
        s = (c ? 64'sd0 : longint'(m16)) + p;
        m16o = (c ? 1'b0 : m16o) | (s > 64'sd32767 || s < -64'sd32768);
        m16 = 16'(s);
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send8(input logic signed [7:0] a, input logic signed [7:0] b,
                         input logic c, input logic l);
        int n;
        exp8_t e;
        n = 0;
        x8 = a; y8 = b; clr = c; last = l; in_valid = 1'b1;
        while (!(in_ready_a === 1'b1) && n < TO) begin
            @(negedge clk);
            n++;
        end
        chk_to("send8_wait", n);
        model8(a, b, c);
        if (l) begin
            e.r24 = m24; e.o24 = m24o; e.r16 = m16; e.o16 = m16o;
            q8.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv8(input string tag);
        int n;
        exp8_t e;
        n = 0;
        while (!(out_valid_a === 1'b1) && n < TO) begin
            @(negedge clk);
            n++;
        end
        chk_to({tag, "_wait"}, n);
        checks++;
        assert (q8.size() > 0)
        else begin
            errors++;
            $error("FAIL %s_sb: observed result with empty scoreboard, expected none", tag);
        end
        if (q8.size() > 0) begin
            e = q8.pop_front();
            chk({tag, "_ovalid_b"}, 64'(out_valid_b), 64'sd1);
            chk({tag, "_res24"}, $signed(result_a), e.r24);
            chk({tag, "_ovf24"}, 64'(ovf_a), 64'(e.o24));
            chk({tag, "_res16"}, $signed(result_b), e.r16);
            chk({tag, "_ovf16"}, 64'(ovf_b), 64'(e.o16));
        end
        @(negedge clk);
    endtask

    task automatic run4(input logic signed [3:0] a, input logic signed [3:0] b);
        int n;
        n = 0;
        x4 = a; y4 = b; iv4 = 1'b1;
        while (!(rdy4 === 1'b1) && n < TO) begin @(negedge clk); n++; end
        chk_to("w4_send", n);
        qw.push_back(longint'(a) * longint'(b));
        @(negedge clk);
        iv4 = 1'b0;
        n = 0;
        while (!(ov4 === 1'b1) && n < TO) begin @(negedge clk); n++; end
        chk_to("w4_recv", n);
        chk("w4_prod", $signed(res4), qw.pop_front());
        @(negedge clk);
    endtask

    task automatic run16(input logic signed [15:0] a, input logic signed [15:0] b);
        int n;
        n = 0;
        x16 = a; y16 = b; iv16 = 1'b1;
        while (!(rdy16 === 1'b1) && n < TO) begin @(negedge clk); n++; end
        chk_to("w16_send", n);
        qw.push_back(longint'(a) * longint'(b));
        @(negedge clk);
        iv16 = 1'b0;
        n = 0;
        while (!(ov16 === 1'b1) && n < TO) begin @(negedge clk); n++; end
        chk_to("w16_recv", n);
        chk("w16_prod", $signed(res16), qw.pop_front());
        @(negedge clk);
    endtask

    // Hard stop in case a wait somewhere is not bounded as expected.
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [7:0] cv[6];
        logic signed [7:0] ra, rb;
        logic signed [15:0] wa, wb;
        logic rc, rl;

        cv[0] = -8'sd128; cv[1] = -8'sd127; cv[2] = -8'sd1;
        cv[3] = 8'sd0;    cv[4] = 8'sd1;    cv[5] = 8'sd127;

        rst = 1'b1; in_valid = 1'b0; clr = 1'b0; last = 1'b0; out_ready = 1'b1;
        x8 = '0; y8 = '0; iv4 = 1'b0; iv16 = 1'b0; one = 1'b1;
        x4 = '0; y4 = '0; x16 = '0; y16 = '0;
        m24 = '0; m24o = 1'b0; m16 = '0; m16o = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_iready", 64'(in_ready_a), 64'sd0);
        chk("rst_ovalid", 64'(out_valid_a), 64'sd0);
        chk("rst_result", $signed(result_a), 64'sd0);
        chk("rst_ovf", 64'(ovf_a), 64'sd0);
        rst = 1'b0;
        #1;
        chk("rel_iready", 64'(in_ready_a), 64'sd1);
        @(negedge clk);

        // Single products with latency check
        send8(-8'sd128, -8'sd128, 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("lat_ovalid", 64'(out_valid_a), (i == 5) ? 64'sd1 : 64'sd0);
            chk("lat_iready", 64'(in_ready_a), 64'sd0);
        end
        chk("m128sq_direct", $signed(result_a), 64'sd16384);
        recv8("m128sq");
        chk("post_ovalid", 64'(out_valid_a), 64'sd0);
        chk("post_iready", 64'(in_ready_a), 64'sd1);
        send8(8'sd37, -8'sd86, 1'b1, 1'b1);
        recv8("p37x86");
        chk("p37x86_direct", $signed(result_a), -64'sd3182);
        send8(-8'sd1, 8'sd0, 1'b1, 1'b1);
        recv8("pm1x0");

        // Accumulation group
        send8(8'sd3, 8'sd5, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("grp_iready", 64'(in_ready_a), (i == 5) ? 64'sd1 : 64'sd0);
            chk("grp_ovalid", 64'(out_valid_a), 64'sd0);
        end
        send8(-8'sd7, 8'sd2, 1'b0, 1'b0);
        send8(8'sd127, -8'sd128, 1'b0, 1'b1);
        recv8("group");
        chk("group_direct", $signed(result_a), -64'sd16255);
        chk("group_ovalid_after", 64'(out_valid_a), 64'sd0);
        chk("group_sb_empty", 64'(q8.size()), 64'sd0);

        // Backpressure with an ignored in_valid pulse
        out_ready = 1'b0;
        send8(8'sd100, -8'sd3, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin x8 = 8'sd55; y8 = 8'sd55; clr = 1'b1; in_valid = 1'b1; end
            if (i == 4) in_valid = 1'b0;
            chk("bp_ovalid", 64'(out_valid_a), 64'sd1);
            chk("bp_result", $signed(result_a), -64'sd300);
            chk("bp_iready", 64'(in_ready_a), 64'sd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        recv8("bp");
        chk("bp_ovalid_after", 64'(out_valid_a), 64'sd0);
        chk("bp_iready_after", 64'(in_ready_a), 64'sd1);
        send8(8'sd2, 8'sd3, 1'b0, 1'b1);
        recv8("retain");
        chk("retain_direct", $signed(result_a), -64'sd294);

        // Overflow: wraps in the 16-bit accumulator only
        send8(-8'sd128, -8'sd128, 1'b1, 1'b0);
        send8(-8'sd128, -8'sd128, 1'b0, 1'b0);
        send8(-8'sd128, -8'sd128, 1'b0, 1'b1);
        recv8("ovf");
        chk("ovf_res16_direct", $signed(result_b), -64'sd16384);
        chk("ovf_flag_direct", 64'(ovf_b), 64'sd1);
        send8(8'sd1, 8'sd1, 1'b1, 1'b1);
        recv8("ovf_clr");
        chk("ovf_clr_flag", 64'(ovf_b), 64'sd0);

        // Corner operand products
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
                send8(cv[i], cv[j], 1'b1, 1'b1);
                recv8("corner");
            end

        // Random groups
        for (int i = 0; i < 1200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = ($urandom_range(0, 3) == 0) || (i == 0);
            rl = ($urandom_range(0, 2) == 0) || (i == 1199);
            send8(ra, rb, rc, rl);
            if (rl) recv8("rand8");
        end

        // Reset mid-MUL
        send8(8'sd9, 8'sd9, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_iready", 64'(in_ready_a), 64'sd0);
        @(negedge clk);
        chk("mid_rst_ovalid", 64'(out_valid_a), 64'sd0);
        chk("mid_rst_result", $signed(result_a), 64'sd0);
        chk("mid_rst_ovf", 64'(ovf_b), 64'sd0);
        q8.delete();
        m24 = '0; m24o = 1'b0; m16 = '0; m16o = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_rel_iready", 64'(in_ready_a), 64'sd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mid_rst_no_emit", 64'(out_valid_a), 64'sd0);
        end
        send8(8'sd5, -8'sd6, 1'b1, 1'b1);
        recv8("after_rst");
        chk("after_rst_direct", $signed(result_a), -64'sd30);

        // W=4: every operand pair
        for (int i = -8; i < 8; i++)
            for (int j = -8; j < 8; j++)
                run4(4'(i), 4'(j));

        // W=16: corners and random vectors
        run16(-16'sd32768, -16'sd32768);
        run16(-16'sd32768, 16'sd32767);
        run16(16'sd32767, 16'sd32767);
        run16(-16'sd1, -16'sd1);
        for (int i = 0; i < 300; i++) begin
            wa = 16'($urandom_range(0, 65535));
            wb = 16'($urandom_range(0, 65535));
            run16(wa, wb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
